// File: rtl/jtag_a_pkg_hdl.sv
// Shared TAP definitions: state encoding, opcodes, DR select and next-state helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jtag_a_pkg_hdl;

    typedef enum logic [3:0] {
        EX2_DR   = 4'h0,
        EX1_DR   = 4'h1,
        SHIFT_DR = 4'h2,
        PAUSE_DR = 4'h3,
        SEL_IR   = 4'h4,
        UPD_DR   = 4'h5,
        CAP_DR   = 4'h6,
        SEL_DR   = 4'h7,
        EX2_IR   = 4'h8,
        EX1_IR   = 4'h9,
        SHIFT_IR = 4'hA,
        PAUSE_IR = 4'hB,
        RTI      = 4'hC,
        UPD_IR   = 4'hD,
        CAP_IR   = 4'hE,
        TLR      = 4'hF
    } jtag_a_tap_state_t;

    localparam logic [3:0] JTAG_A_IR_IDCODE   = 4'h1;
    localparam logic [3:0] JTAG_A_IR_USER     = 4'h8;
    localparam logic [3:0] JTAG_A_IR_BYPASS   = 4'hF;
    localparam logic [3:0] JTAG_A_IR_USERCODE = 4'h3;

    // Fixed pattern loaded into the IR shift register at Capture-IR.
    localparam logic [1:0] JTAG_A_IR_CAPTURE  = 2'b01;

    // Which data register sits between tdi and tdo for the current instruction.
    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER,
        DR_USERCODE
    } jtag_a_dr_sel_t;

    function automatic jtag_a_tap_state_t jtag_a_next_state(input jtag_a_tap_state_t s,
                                                           input logic tms);
        jtag_a_tap_state_t n;
        n = TLR;
        case (s)
            TLR:      n = tms ? TLR      : RTI;
            RTI:      n = tms ? SEL_DR   : RTI;
            SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
            SEL_IR:   n = tms ? TLR      : CAP_IR;
            CAP_DR:   n = tms ? EX1_DR   : SHIFT_DR;
            SHIFT_DR: n = tms ? EX1_DR   : SHIFT_DR;
            EX1_DR:   n = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: n = tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   n = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   n = tms ? SEL_DR   : RTI;
            CAP_IR:   n = tms ? EX1_IR   : SHIFT_IR;
            SHIFT_IR: n = tms ? EX1_IR   : SHIFT_IR;
            EX1_IR:   n = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: n = tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   n = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   n = tms ? SEL_DR   : RTI;
            default:  n = TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_a_tap_fsm.sv
// 16-state TAP controller with decoded per-state action strobes.
// Latency: state advances every TCK edge; strobes decode the registered state.
// Backpressure: none, tms is consumed every cycle.
module jtag_a_tap_fsm
    import jtag_a_pkg_hdl::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       tms,
    output logic [3:0] tap_state,
    output logic       st_tlr,
    output logic       st_cap_dr,
    output logic       st_shift_dr,
    output logic       st_upd_dr,
    output logic       st_cap_ir,
    output logic       st_shift_ir,
    output logic       st_upd_ir,
    output logic       nx_shift_dr,
    output logic       nx_shift_ir
);

    jtag_a_tap_state_t state;
    jtag_a_tap_state_t next_state;

    // Next state from current state and tms.
    always_comb begin
        next_state = jtag_a_next_state(state, tms);
    end

    // State register; reset forces Test-Logic-Reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    assign tap_state   = state;
    assign st_tlr      = (state == TLR);
    assign st_cap_dr   = (state == CAP_DR);
    assign st_shift_dr = (state == SHIFT_DR);
    assign st_upd_dr   = (state == UPD_DR);
    assign st_cap_ir   = (state == CAP_IR);
    assign st_shift_ir = (state == SHIFT_IR);
    assign st_upd_ir   = (state == UPD_IR);
    // Look-ahead so tdo/tdo_en can be registered on the edge entering Shift-x.
    assign nx_shift_dr = (next_state == SHIFT_DR);
    assign nx_shift_ir = (next_state == SHIFT_IR);

endmodule

// File: rtl/jtag_a_tap_target.sv
// TAP target: IR, BYPASS/IDCODE/USER data registers, registered tdo. Optional
// USERCODE register is built when JTAG_A_TAP_USERCODE_EN is defined.
// Latency: tdo lags tdi by the selected register length; Backpressure: none.
module jtag_a_tap_target
    import jtag_a_pkg_hdl::*;
#(
    parameter int          IR_WIDTH       = 4,
    parameter int          DR_WIDTH       = 16,
`ifdef JTAG_A_TAP_USERCODE_EN
    parameter logic [31:0] USERCODE_VALUE = 32'h0000_0001,
`endif
    parameter logic [31:0] IDCODE_VALUE   = 32'h1A5A_5093
)(
    input  logic                clock,
    input  logic                reset,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_value,
    input  logic [DR_WIDTH-1:0] user_capture_data,
    output logic [DR_WIDTH-1:0] user_update_data,
    output logic                user_update_valid
);

    localparam logic [IR_WIDTH-1:0] OP_IDCODE   = IR_WIDTH'(JTAG_A_IR_IDCODE);
    localparam logic [IR_WIDTH-1:0] OP_USER     = IR_WIDTH'(JTAG_A_IR_USER);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(JTAG_A_IR_CAPTURE);
`ifdef JTAG_A_TAP_USERCODE_EN
    localparam logic [IR_WIDTH-1:0] OP_USERCODE = IR_WIDTH'(JTAG_A_IR_USERCODE);
`endif

    logic st_tlr, st_cap_dr, st_shift_dr, st_upd_dr;
    logic st_cap_ir, st_shift_ir, st_upd_ir;
    logic nx_shift_dr, nx_shift_ir;

    jtag_a_tap_fsm u_fsm (
        .clock       (clock),
        .reset       (reset),
        .tms         (tms),
        .tap_state   (tap_state),
        .st_tlr      (st_tlr),
        .st_cap_dr   (st_cap_dr),
        .st_shift_dr (st_shift_dr),
        .st_upd_dr   (st_upd_dr),
        .st_cap_ir   (st_cap_ir),
        .st_shift_ir (st_shift_ir),
        .st_upd_ir   (st_upd_ir),
        .nx_shift_dr (nx_shift_dr),
        .nx_shift_ir (nx_shift_ir)
    );

    logic [IR_WIDTH-1:0] ir_sr, ir_sr_d;
    logic [31:0]         id_sr, id_sr_d;
    logic [DR_WIDTH-1:0] user_sr, user_sr_d;
    logic                byp_sr, byp_sr_d;
    logic [DR_WIDTH:0]   user_cat;
`ifdef JTAG_A_TAP_USERCODE_EN
    logic [31:0]         uc_sr, uc_sr_d;
`endif
    jtag_a_dr_sel_t      dr_sel;
    logic                dr_bit;

    // Instruction decode; unknown opcodes fall through to BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_value == OP_IDCODE) begin
            dr_sel = DR_IDCODE;
        end else if (ir_value == OP_USER) begin
            dr_sel = DR_USER;
        end
`ifdef JTAG_A_TAP_USERCODE_EN
        else if (ir_value == OP_USERCODE) begin
            dr_sel = DR_USERCODE;
        end
`endif
    end

    // Capture/shift values for this edge; only the selected DR moves.
    always_comb begin
        ir_sr_d   = ir_sr;
        id_sr_d   = id_sr;
        user_sr_d = user_sr;
        byp_sr_d  = byp_sr;
        user_cat  = {tdi, user_sr};
`ifdef JTAG_A_TAP_USERCODE_EN
        uc_sr_d   = uc_sr;
`endif
        if (st_cap_ir) begin
            ir_sr_d = IR_CAPTURE;
        end else if (st_shift_ir) begin
            ir_sr_d = {tdi, ir_sr[IR_WIDTH-1:1]};
        end
        case (dr_sel)
            DR_IDCODE: begin
                if (st_cap_dr)        id_sr_d = IDCODE_VALUE;
                else if (st_shift_dr) id_sr_d = {tdi, id_sr[31:1]};
            end
            DR_USER: begin
                if (st_cap_dr)        user_sr_d = user_capture_data;
                else if (st_shift_dr) user_sr_d = user_cat[DR_WIDTH:1];
            end
`ifdef JTAG_A_TAP_USERCODE_EN
            DR_USERCODE: begin
                if (st_cap_dr)        uc_sr_d = USERCODE_VALUE;
                else if (st_shift_dr) uc_sr_d = {tdi, uc_sr[31:1]};
            end
`endif
            default: begin
                if (st_cap_dr)        byp_sr_d = 1'b0;
                else if (st_shift_dr) byp_sr_d = tdi;
            end
        endcase
    end

    // Bit that will be presented on tdo if the next state is Shift-DR.
    always_comb begin
        dr_bit = byp_sr_d;
        case (dr_sel)
            DR_IDCODE:   dr_bit = id_sr_d[0];
            DR_USER:     dr_bit = user_sr_d[0];
`ifdef JTAG_A_TAP_USERCODE_EN
            DR_USERCODE: dr_bit = uc_sr_d[0];
`endif
            default:     dr_bit = byp_sr_d;
        endcase
    end

    // Shift registers, instruction, user update port and registered tdo.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_sr             <= '0;
            id_sr             <= '0;
            user_sr           <= '0;
            byp_sr            <= 1'b0;
`ifdef JTAG_A_TAP_USERCODE_EN
            uc_sr             <= '0;
`endif
            ir_value          <= OP_IDCODE;
            user_update_data  <= '0;
            user_update_valid <= 1'b0;
            tdo               <= 1'b0;
            tdo_en            <= 1'b0;
        end else begin
            ir_sr   <= ir_sr_d;
            id_sr   <= id_sr_d;
            user_sr <= user_sr_d;
            byp_sr  <= byp_sr_d;
`ifdef JTAG_A_TAP_USERCODE_EN
            uc_sr   <= uc_sr_d;
`endif
            if (st_tlr) begin
                ir_value <= OP_IDCODE;
            end else if (st_upd_ir) begin
                ir_value <= ir_sr;
            end
            user_update_valid <= st_upd_dr && (dr_sel == DR_USER);
            if (st_upd_dr && (dr_sel == DR_USER)) begin
                user_update_data <= user_sr;
            end
            if (nx_shift_ir) begin
                tdo    <= ir_sr_d[0];
                tdo_en <= 1'b1;
            end else if (nx_shift_dr) begin
                tdo    <= dr_bit;
                tdo_en <= 1'b1;
            end else begin
                tdo    <= 1'b0;
                tdo_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtag_a_tap_target.sv
// Self-checking bench for jtag_a_tap_target: scoreboard of expected tdo bits.
// Latency: n/a; Backpressure: n/a.
// Stimulus changes on the falling edge; tdo is sampled just before each rising edge.
module tb_jtag_a_tap_target;

    localparam logic [31:0] IDCODE   = 32'h1A5A_5093;
    localparam logic [31:0] USERCODE = 32'h0000_0001;

    logic        clock, reset, tms, tdi, tdo, tdo_en;
    logic [3:0]  tap_state, ir_value;
    logic [15:0] user_capture_data, user_update_data;
    logic        user_update_valid;

    int checks = 0;
    int errors = 0;
    bit obs_q[$];
    bit exp_q[$];

    jtag_a_tap_target dut (
        .clock             (clock),
        .reset             (reset),
        .tms               (tms),
        .tdi               (tdi),
        .tdo               (tdo),
        .tdo_en            (tdo_en),
        .tap_state         (tap_state),
        .ir_value          (ir_value),
        .user_capture_data (user_capture_data),
        .user_update_data  (user_update_data),
        .user_update_valid (user_update_valid)
    );

    always #5 clock = ~clock;

    // One TCK: drive tms/tdi, record tdo as the initiator would, advance to next falling edge.
    task automatic tck(input logic m, input logic d);
        tms = m;
        tdi = d;
        if (tdo_en === 1'b1) obs_q.push_back(tdo);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic shift_bits(input logic [63:0] data, input int n);
        for (int i = 0; i < n; i++) tck(i == n - 1, data[i]);
    endtask

    task automatic to_shift_dr();
        tck(1, 0); tck(0, 0); tck(0, 0);
    endtask

    task automatic finish_update();
        tck(1, 0); tck(0, 0);
    endtask

    task automatic load_ir(input logic [3:0] op);
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        shift_bits({60'd0, op}, 4);
        finish_update();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tck(0, 0); tck(0, 0);
        checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL rst_state: got %h expected F", tap_state); end
        checks++; if (ir_value !== 4'h1) begin errors++; $display("FAIL rst_ir: got %h expected 1", ir_value); end
        checks++; if (tdo !== 1'b0 || tdo_en !== 1'b0) begin errors++; $display("FAIL rst_tdo: got %b/%b expected 0/0", tdo, tdo_en); end
        checks++; if (user_update_data !== 16'h0 || user_update_valid !== 1'b0) begin errors++; $display("FAIL rst_user: got %h/%b expected 0/0", user_update_data, user_update_valid); end
        reset = 1'b0;
    endtask

    task automatic test_idcode();
        int k = 0;
        bit o, e;
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE[i]);
        tck(0, 0);
        to_shift_dr();
        shift_bits({32'd0, $urandom}, 32);
        finish_update();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL idcode_len: got %0d enabled bits expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL idcode_bit%0d: got %b expected %b", k, o, e); end
            k++;
        end
    endtask

    task automatic test_ir_capture();
        int k = 0;
        bit o, e;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        load_ir(4'hF);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ircap_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL ircap_bit%0d: got %b expected %b", k, o, e); end
            k++;
        end
        checks++; if (ir_value !== 4'hF) begin errors++; $display("FAIL ircap_value: got %h expected F", ir_value); end
    endtask

    task automatic test_bypass();
        logic [7:0] pat = 8'b1011_0010;
        int k = 0;
        bit o, e;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back(0);
        for (int i = 0; i < 7; i++) exp_q.push_back(pat[i]);
        to_shift_dr();
        shift_bits({56'd0, pat}, 8);
        finish_update();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bypass_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL bypass_bit%0d: got %b expected %b", k, o, e); end
            k++;
        end
    endtask

    task automatic test_user();
        logic [15:0] cap = 16'hBEEF;
        int k = 0;
        bit o, e;
        load_ir(4'h8);
        checks++; if (ir_value !== 4'h8) begin errors++; $display("FAIL user_ir: got %h expected 8", ir_value); end
        obs_q.delete(); exp_q.delete();
        user_capture_data = cap;
        for (int i = 0; i < 16; i++) exp_q.push_back(cap[i]);
        to_shift_dr();
        shift_bits(64'h1234, 16);
        tck(1, 0);
        checks++; if (user_update_valid !== 1'b0) begin errors++; $display("FAIL user_early_valid: got %b expected 0", user_update_valid); end
        tck(0, 0);
        checks++; if (user_update_valid !== 1'b1 || user_update_data !== 16'h1234) begin errors++; $display("FAIL user_update: got %b/%h expected 1/1234", user_update_valid, user_update_data); end
        tck(0, 0);
        checks++; if (user_update_valid !== 1'b0) begin errors++; $display("FAIL user_pulse_width: got %b expected 0", user_update_valid); end
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL user_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL user_bit%0d: got %b expected %b", k, o, e); end
            k++;
        end
    endtask

    task automatic test_tlr_escape();
        int pulses = 0;
        load_ir(4'h1);
        to_shift_dr();
        tck(0, 1); tck(0, 1);
        repeat (5) begin tck(1, 0); if (user_update_valid === 1'b1) pulses++; end
        checks++; if (tap_state !== 4'hF) begin errors++; $display("FAIL tlr_state: got %h expected F", tap_state); end
        checks++; if (ir_value !== 4'h1 || pulses != 0) begin errors++; $display("FAIL tlr_idcode: got ir %h pulses %0d expected 1/0", ir_value, pulses); end
        tck(0, 0);
        load_ir(4'hF);
        to_shift_dr();
        repeat (5) tck(1, 0);
        checks++; if (tap_state !== 4'hF || ir_value !== 4'hF) begin errors++; $display("FAIL tlr_arrive: got %h/%h expected F/F", tap_state, ir_value); end
        tck(1, 0);
        checks++; if (ir_value !== 4'h1) begin errors++; $display("FAIL tlr_ir_reset: got %h expected 1", ir_value); end
    endtask

    task automatic test_pause();
        int k = 0;
        bit o, e;
        tck(0, 0);
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(IDCODE[i]);
        to_shift_dr();
        repeat (9) tck(0, 1);
        tck(1, 0);
        tck(0, 0);
        repeat (3) tck(0, 1);
        checks++; if (tap_state !== 4'h3) begin errors++; $display("FAIL pause_state: got %h expected 3", tap_state); end
        tck(1, 0);
        tck(0, 0);
        repeat (21) tck(0, 0);
        tck(1, 0);
        finish_update();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL pause_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL pause_bit%0d: got %b expected %b", k, o, e); end
            k++;
        end
    endtask

    task automatic test_reset_mid_shift();
        int pulses = 0;
        load_ir(4'h8);
        user_capture_data = 16'hA5C3;
        to_shift_dr();
        repeat (8) tck(0, 1);
        reset = 1'b1;
        tck(0, 1);
        reset = 1'b0;
        checks++; if (tap_state !== 4'hF || ir_value !== 4'h1) begin errors++; $display("FAIL midrst_state: got %h/%h expected F/1", tap_state, ir_value); end
        checks++; if (tdo !== 1'b0 || tdo_en !== 1'b0) begin errors++; $display("FAIL midrst_tdo: got %b/%b expected 0/0", tdo, tdo_en); end
        checks++; if (user_update_data !== 16'h0 || user_update_valid !== 1'b0) begin errors++; $display("FAIL midrst_user: got %h/%b expected 0/0", user_update_data, user_update_valid); end
        repeat (3) begin tck(0, 0); if (user_update_valid === 1'b1) pulses++; end
        checks++; if (pulses != 0 || user_update_data !== 16'h0) begin errors++; $display("FAIL midrst_after: got pulses %0d data %h expected 0/0", pulses, user_update_data); end
    endtask

    task automatic test_usercode();
        logic [31:0] d = 32'h89AB_CDEF;
        int k = 0;
        bit o, e;
        load_ir(4'h3);
        obs_q.delete(); exp_q.delete();
`ifdef JTAG_A_TAP_USERCODE_EN
        for (int i = 0; i < 32; i++) exp_q.push_back(USERCODE[i]);
`else
        exp_q.push_back(0);
        for (int i = 0; i < 31; i++) exp_q.push_back(d[i]);
`endif
        to_shift_dr();
        shift_bits({32'd0, d}, 32);
        finish_update();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ucode_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL ucode_bit%0d: got %b expected %b", k, o, e); end
            k++;
        end
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        tms = 1'b1;
        tdi = 1'b0;
        user_capture_data = 16'h0;
        @(negedge clock);
        test_reset();
        test_idcode();
        test_ir_capture();
        test_bypass();
        test_user();
        test_tlr_escape();
        test_pause();
        test_reset_mid_shift();
        test_usercode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
